// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - mdu_op_e      : op_i encodings (MULT .. MSUBU)
//   - mdu_state_e   : engine state encoding
//   - mdu_res_sel_e : what the FIX cycle loads into the result register
//   - helpers       : signedness and divide decode of an op code
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MADD  = 3'd4,
    MDU_OP_MADDU = 3'd5,
    MDU_OP_MSUB  = 3'd6,
    MDU_OP_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  typedef enum logic [1:0] {
    RES_MUL  = 2'd0,  // plain (sign-corrected) product
    RES_DIV  = 2'd1,  // {remainder, quotient}
    RES_MADD = 2'd2,  // hilo + product
    RES_MSUB = 2'd3   // hilo - product
  } mdu_res_sel_e;

  // Even op codes are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// Combinational one-bit restoring division step.
//   rem_i     : partial remainder (always < divisor_i)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
// -----------------------------------------------------------------------------
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor, so the shifted value is < 2*divisor and fits WIDTH+1
  // bits; the top bit of the difference is therefore a clean borrow flag.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative shared multiply / divide / multiply-accumulate engine for EX.
// One operand bit per cycle: WIDTH cycles of MUL or DIV, one FIX cycle for
// sign correction and accumulation, then a one-cycle DONE with ready_o.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   start_i       : request, accepted in IDLE or DONE when annul_i is low
//   annul_i       : abort whatever is in flight (pipeline flush)
//   op_i          : mdu_op_e encoding
//   opdata1_i/2_i : multiplicand/dividend, multiplier/divisor
//   hilo_i        : accumulator source for MADD/MSUB
//   busy_o        : engine occupied (MUL, DIV, FIX), decoded from state
//   ready_o       : one-cycle pulse, result_o/div_zero_o valid
//   result_o      : product/accumulation, or {remainder, quotient}
//   div_zero_o    : the completed divide had a zero divisor
//
// Build option: define MDU_ACCUM_EN for MADD/MADDU/MSUB/MSUBU. Without it
// ops 4/6 behave as MULT, ops 5/7 as MULTU, and hilo_i is ignored.
// -----------------------------------------------------------------------------
module mdu_iter
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_zero_o
);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  wrk_q, wrk_d;      // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]    opnd_q, opnd_d;    // multiplicand or divisor magnitude
  mdu_res_sel_e        sel_q, sel_d;
  logic                neg_q, neg_d;      // negate product / quotient
  logic                neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]  res_q, res_d;
  logic                dz_q, dz_d;
  logic                ready_q, ready_d;
`ifdef MDU_ACCUM_EN
  logic [2*WIDTH-1:0]  hilo_q, hilo_d;
`else
  logic                unused_hilo;
  assign unused_hilo = ^hilo_i;
`endif

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------------
  logic             sgn, a_neg, b_neg, is_div;
  logic [WIDTH-1:0] a_abs, b_abs;
  mdu_res_sel_e     mul_sel;

  assign sgn    = op_is_signed(op_i);
  assign is_div = op_is_div(op_i);
  assign a_neg  = sgn & opdata1_i[WIDTH-1];
  assign b_neg  = sgn & opdata2_i[WIDTH-1];
  // -0x8000_0000 wraps back to itself, which is the correct unsigned magnitude.
  assign a_abs  = a_neg ? -opdata1_i : opdata1_i;
  assign b_abs  = b_neg ? -opdata2_i : opdata2_i;

  always_comb begin
    mul_sel = RES_MUL;
`ifdef MDU_ACCUM_EN
    if (op_i[2]) mul_sel = op_i[1] ? RES_MSUB : RES_MADD;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath steps
  // ---------------------------------------------------------------------------
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole work register right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, wrk_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (wrk_q[0] ? opnd_q : {WIDTH{1'b0}})};

  logic [WIDTH-1:0] div_rem;
  logic             div_q;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (wrk_q[2*WIDTH-1:WIDTH]),
    .bit_i     (wrk_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  logic               last_iter;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // FIX-cycle sign correction and accumulation (modulo 2^(2*WIDTH)).
  logic [2*WIDTH-1:0] prod_fix, fix_res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q     ? -wrk_q : wrk_q;
    quo_fix  = neg_q     ? -wrk_q[WIDTH-1:0]       : wrk_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -wrk_q[2*WIDTH-1:WIDTH] : wrk_q[2*WIDTH-1:WIDTH];
    case (sel_q)
      RES_DIV:  fix_res = {rem_fix, quo_fix};
`ifdef MDU_ACCUM_EN
      RES_MADD: fix_res = hilo_q + prod_fix;
      RES_MSUB: fix_res = hilo_q - prod_fix;
`endif
      default:  fix_res = prod_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a hold/default value first so no path through
    // the case statement leaves a signal unassigned (which would infer a latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrk_d     = wrk_q;
    opnd_d    = opnd_q;
    sel_d     = sel_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    dz_d      = dz_q;
    ready_d   = 1'b0;
`ifdef MDU_ACCUM_EN
    hilo_d    = hilo_q;
`endif

    if (annul_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start_i) begin
            cnt_d     = '0;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
`ifdef MDU_ACCUM_EN
            hilo_d    = hilo_i;
`endif
            if (is_div) begin
              sel_d  = RES_DIV;
              opnd_d = b_abs;
              wrk_d  = {{WIDTH{1'b0}}, a_abs};
              if (opdata2_i == '0) begin
                state_d = ST_DONE;
                res_d   = '0;
                dz_d    = 1'b1;
                ready_d = 1'b1;
              end else begin
                state_d = ST_DIV;
              end
            end else begin
              sel_d   = mul_sel;
              opnd_d  = a_abs;
              wrk_d   = {{WIDTH{1'b0}}, b_abs};
              state_d = ST_MUL;
            end
          end
        end
        ST_MUL: begin
          wrk_d = {mul_sum, wrk_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) state_d = ST_FIX;
        end
        ST_DIV: begin
          wrk_d = {div_rem, wrk_q[WIDTH-2:0], div_q};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) state_d = ST_FIX;
        end
        ST_FIX: begin
          res_d   = fix_res;
          dz_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wrk_q     <= '0;
      opnd_q    <= '0;
      sel_q     <= RES_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      dz_q      <= 1'b0;
      ready_q   <= 1'b0;
`ifdef MDU_ACCUM_EN
      hilo_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wrk_q     <= wrk_d;
      opnd_q    <= opnd_d;
      sel_q     <= sel_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
      dz_q      <= dz_d;
      ready_q   <= ready_d;
`ifdef MDU_ACCUM_EN
      hilo_q    <= hilo_d;
`endif
    end
  end

  assign busy_o     = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign ready_o    = ready_q;
  assign result_o   = res_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
// Self-checking bench for mdu_iter (WIDTH=32). Directed cases plus random
// operations compared against an arithmetic reference model. Honours
// MDU_ACCUM_EN for the expected accumulate behaviour.
// -----------------------------------------------------------------------------
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            start_i;
  logic            annul_i;
  logic [2:0]      op_i;
  logic [W-1:0]    opdata1_i;
  logic [W-1:0]    opdata2_i;
  logic [2*W-1:0]  hilo_i;
  logic            busy_o;
  logic            ready_o;
  logic [2*W-1:0]  result_o;
  logic            div_zero_o;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [2*W-1:0]  last_res = '0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .hilo_i     (hilo_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the op semantics.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2*W-1:0] hilo,
                                output logic [2*W-1:0] res, output logic dz);
    longint         sa, sb;
    logic [2*W-1:0] prod;
    logic [W-1:0]   q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (op == 3'd2 || op == 3'd3) begin
      if (b == '0) begin
        res = '0;
        dz  = 1'b1;
      end else begin
        if (op == 3'd2) begin
          q = W'(sa / sb);
          r = W'(sa % sb);
        end else begin
          q = a / b;
          r = a % b;
        end
        res = {r, q};
      end
    end else begin
      if (op[0]) prod = {32'd0, a} * {32'd0, b};
      else       prod = 64'(sa * sb);
      res = prod;
      if (ACCUM && op[2]) res = op[1] ? hilo - prod : hilo + prod;
    end
  endfunction

  // Called just after a negedge; issues the op so the next posedge is E0,
  // then follows busy_o/ready_o cycle by cycle. Returns in the ready cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] hilo,
                        input logic [2*W-1:0] exp_res, input logic exp_dz);
    int rdy_cyc;
    int busy_err;
    int exp_cyc;
    exp_cyc   = exp_dz ? 1 : W + 2;
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    hilo_i    = hilo;
    @(posedge clk);
    #1 start_i = 1'b0;
    rdy_cyc  = 0;
    busy_err = 0;
    for (int n = 1; n <= W + 6 && rdy_cyc == 0; n++) begin
      @(negedge clk);
      if (ready_o) begin
        rdy_cyc = n;
        if (busy_o) busy_err++;
      end else if (!busy_o) begin
        busy_err++;
      end
    end
    check({tag, "_ready_cycle"}, 64'(rdy_cyc), 64'(exp_cyc));
    check({tag, "_busy"}, 64'(busy_err), 64'd0);
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_div_zero"}, 64'(div_zero_o), 64'(exp_dz));
    last_res = exp_res;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] exp_res;
    logic           exp_dz;
    logic [2:0]     rop;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] rh;
    int             seen_rdy;

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
    opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
    #1;
    check("reset_busy",   64'(busy_o),     64'd0);
    check("reset_ready",  64'(ready_o),    64'd0);
    check("reset_result", result_o,        64'd0);
    check("reset_dz",     64'(div_zero_o), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases, issued back to back from DONE after the first.
    run_op("mult_m2x3", MDU_OP_MULT, 32'hFFFF_FFFE, 32'h3, '0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("div_m7d2",  MDU_OP_DIV,  32'hFFFF_FFF9, 32'h2, '0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_ovf",   MDU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, '0, 64'h0000_0000_8000_0000, 1'b0);
    run_op("divu_5d0",  MDU_OP_DIVU, 32'd5, 32'd0, '0, 64'h0, 1'b1);
    run_op("divu_9d4",  MDU_OP_DIVU, 32'd9, 32'd4, '0, 64'h0000_0001_0000_0002, 1'b0);
    run_op("msub",      MDU_OP_MSUB, 32'd3, 32'd4, 64'h10, ACCUM ? 64'h4 : 64'hC, 1'b0);
    run_op("maddu_wrap", MDU_OP_MADDU, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF,
           ACCUM ? 64'h0 : 64'h1, 1'b0);

    // Annul at cycle 10 of a DIV: no ready, idle next cycle, result kept.
    start_i = 1'b1; op_i = MDU_OP_DIV; opdata1_i = 32'd100; opdata2_i = 32'hFFFF_FFF9;
    @(posedge clk);
    #1 start_i = 1'b0;
    seen_rdy = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ready_o) seen_rdy++;
    end
    annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    @(negedge clk);
    if (ready_o) seen_rdy++;
    check("annul_no_ready", 64'(seen_rdy), 64'd0);
    check("annul_busy",     64'(busy_o),   64'd0);
    check("annul_result",   result_o,      last_res);
    run_op("after_annul", MDU_OP_DIV, 32'd100, 32'hFFFF_FFF9, '0, 64'h0000_0002_FFFF_FFF2, 1'b0);

    // Asynchronous reset at cycle 15 of a MULT.
    start_i = 1'b1; op_i = MDU_OP_MULT; opdata1_i = 32'd7; opdata2_i = 32'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_busy",   64'(busy_o),     64'd0);
    check("rst_mid_ready",  64'(ready_o),    64'd0);
    check("rst_mid_result", result_o,        64'd0);
    check("rst_mid_dz",     64'(div_zero_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0,
           64'hFFFF_FFFE_0000_0001, 1'b0);

    // Random operations against the reference model, some from IDLE.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      rh  = {$urandom, $urandom};
      model(rop, ra, rb, rh, exp_res, exp_dz);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op("rand", rop, ra, rb, rh, exp_res, exp_dz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative, parametrised multiply/divide unit serving the EX stage. It replaces the single-cycle multiplier and the separate divider handshake with one shared multi-cycle engine. The engine covers signed and unsigned multiply, divide, and multiply-accumulate/subtract into a 2·WIDTH HI/LO value. EX raises `start_i`, stalls while `busy_o` is high, and forwards `result_o` to HI/LO when `ready_o` pulses. `annul_i` aborts the operation on a flush.

## Interface
- `WIDTH`, 32: operand width; result is 2·WIDTH, {HI, LO}.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width (derived; do not override).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  request; sampled only in IDLE or DONE.
- `annul_i`  in  1  abort current operation (pipeline flush).
- `op_i`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `opdata1_i`  in  WIDTH  multiplicand / dividend.
- `opdata2_i`  in  WIDTH  multiplier / divisor.
- `hilo_i`  in  2·WIDTH  accumulator source for MADD/MSUB; already forwarded by EX.
- `busy_o`  out  1  high in MUL, DIV, FIX.
- `ready_o`  out  1  one-cycle pulse; result valid.
- `result_o`  out  2·WIDTH  multiply: product or accumulate; divide: {remainder, quotient}.
- `div_zero_o`  out  1  qualifies `ready_o`; the divisor was zero.

## Operation
- **Reset:** state IDLE, counter 0. `busy_o`, `ready_o`, `div_zero_o` and `result_o` are all 0.
- **Accept:** `start_i=1` with `annul_i=0` in IDLE or DONE. Registers `op_i`, the absolute values of both operands (signed ops only), `hilo_i`, and the result-sign flags. Goes to MUL for ops 0,1,4–7 and to DIV for ops 2,3.
- **DIV with zero divisor:** goes straight to DONE with `result_o=0` and `div_zero_o=1`.
- **MUL:** shift-add, one multiplier bit per cycle, WIDTH cycles. Then FIX.
- **DIV:** restoring division, one quotient bit per cycle, WIDTH cycles. Then FIX.
- **FIX (one cycle):**
  - Negate the product if the operand signs differ (signed ops).
  - Quotient is negative if the signs differ; remainder takes the sign of the dividend.
  - MADD/MADDU: `result = hilo + product`. MSUB/MSUBU: `result = hilo − product`. Arithmetic is modulo 2^(2·WIDTH).
  - Load `result_o`, then go to DONE.
- **DONE:** `ready_o=1` for exactly this cycle. Without a new start, return to IDLE. A start here is accepted (back-to-back operation).
- `result_o` holds its value until the next FIX or divide-by-zero load. `div_zero_o` updates on the same load.
- **Signed overflow:** 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0. This is not flagged.
- **Annul:** annul in any state returns to IDLE on the next edge. No `ready_o`; `result_o` is unchanged. Annul together with start means the start is ignored.
- **Async reset mid-operation:** state IDLE immediately; all outputs go to their reset values.

## Timing
- Start sampled on edge E0.
- Multiply/divide: `busy_o` high for cycles 1..WIDTH+1; `ready_o` high in cycle WIDTH+2. For WIDTH=32, that is 34 cycles.
- Divide-by-zero: `ready_o` high in cycle 1.
- A back-to-back start in DONE gives `busy_o` high in the following cycle.
- All outputs are registered except `busy_o`, which is decoded from the state register.

## Configuration
- **`MDU_ACCUM_EN` defined:** ops 4–7 perform MADD/MADDU/MSUB/MSUBU as above.
- **`MDU_ACCUM_EN` undefined:**
  - The `hilo_i` register and the FIX adder are removed.
  - Ops 4/6 execute as MULT and ops 5/7 as MULTU.
  - The `hilo_i` port stays present and is ignored.

## Structure
- **Package `mdu_pkg`:**
  - op encodings MDU_OP_MULT..MDU_OP_MSUBU;
  - state encoding IDLE, MUL, DIV, FIX, DONE;
  - result-select constants.
- **Sub-module `mdu_div_step`:** combinational one-bit restoring step. Inputs are the partial remainder, the dividend bit, and the divisor. Outputs are the next remainder and the quotient bit.
- The multiply step stays inline.

## Test plan
- MULT -2 × 3 (0xFFFFFFFE, 0x3) → `result_o` 0xFFFFFFFF_FFFFFFFA; `ready_o` in cycle 34; `busy_o` high in cycles 1–33.
- DIV -7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO 0x80000000, HI 0.
- DIVU 5 / 0 → `ready_o` in cycle 1, `div_zero_o`=1, `result_o`=0. Next DIVU 9 / 4 → LO 2, HI 1, `div_zero_o`=0.
- With `MDU_ACCUM_EN`:
  - MSUB 3 × 4, hilo 0x10 → 0x4.
  - MADDU 1 × 1, hilo all-ones → 0 (wrap).
- Without the macro: same MSUB → 0xC.
- Annul at cycle 10 of a DIV:
  - no `ready_o`; `busy_o` low the next cycle; `result_o` unchanged.
  - Start the following cycle completes normally.
- Reset asserted at cycle 15 of a MULT → all outputs 0 at once. After release, a MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
